capture_readout_arbiter: RTL

CAPTURE_READOUT_ARBITER -- requirements
Module: capture_readout_arbiter

---
 rtl/capture_readout_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/capture_readout_arbiter.sv
// Multi-channel capture buffer: one hold register and pending flag per channel,
// drained round-robin into a single valid/ready output slot.

module capture_channel #(
    parameter int TIMER_BITWIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_an_i,
    input  logic                      clr_i,
    input  logic                      event_i,
    input  logic [TIMER_BITWIDTH-1:0] value_i,
    input  logic                      grant_i,
    output logic                      pending_o,
    output logic                      overflow_o,
    output logic [TIMER_BITWIDTH-1:0] hold_o
);
    logic                      pending_d, pending_q;
    logic                      overflow_d, overflow_q;
    logic [TIMER_BITWIDTH-1:0] hold_d, hold_q;

    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        hold_d     = hold_q;
        if (clr_i) begin
            pending_d  = 1'b0;
            overflow_d = 1'b0;
            hold_d     = '0;
        end else if (event_i) begin
            // A grant frees the hold register this cycle, so the new value replaces it.
            if (!pending_q || grant_i) begin
                hold_d = value_i;
            end else begin
                overflow_d = 1'b1;
            end
            pending_d = 1'b1;
        end else if (grant_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            hold_q     <= hold_d;
        end
    end

    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;
    assign hold_o     = hold_q;
endmodule

module capture_readout_arbiter #(
    parameter int TIMER_BITWIDTH = 32,
    parameter int NB_CAPTURES    = 10,
    parameter int CH_BITWIDTH    = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_an_i,
    input  logic                                  rst_i,
    input  logic [NB_CAPTURES-1:0]                capture_event_i,
    input  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] captured_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [CH_BITWIDTH-1:0]                out_channel_o,
    output logic [TIMER_BITWIDTH-1:0]             out_value_o,
    output logic [NB_CAPTURES-1:0]                pending_o,
    output logic [NB_CAPTURES-1:0]                overflow_o
);
    localparam logic [CH_BITWIDTH-1:0] LAST_CH = CH_BITWIDTH'(NB_CAPTURES - 1);

    logic [NB_CAPTURES-1:0][TIMER_BITWIDTH-1:0] hold;
    logic [NB_CAPTURES-1:0]                     pending, overflow, grant_vec;
    logic                                       slot_free, any_pending, grant_en;
    logic [CH_BITWIDTH-1:0]                     start_idx, grant_idx;
    logic [TIMER_BITWIDTH-1:0]                  grant_val;

    logic                      out_valid_d, out_valid_q;
    logic [CH_BITWIDTH-1:0]    out_channel_d, out_channel_q;
    logic [TIMER_BITWIDTH-1:0] out_value_d, out_value_q;
    logic [CH_BITWIDTH-1:0]    last_grant_d, last_grant_q;

    genvar g;
    generate
        for (g = 0; g < NB_CAPTURES; g++) begin : g_ch
            assign grant_vec[g] = grant_en && (grant_idx == CH_BITWIDTH'(g));
            capture_channel #(.TIMER_BITWIDTH(TIMER_BITWIDTH)) u_ch (
                .clk_i      (clk_i),
                .rst_an_i   (rst_an_i),
                .clr_i      (rst_i),
                .event_i    (capture_event_i[g]),
                .value_i    (captured_i[g*TIMER_BITWIDTH +: TIMER_BITWIDTH]),
                .grant_i    (grant_vec[g]),
                .pending_o  (pending[g]),
                .overflow_o (overflow[g]),
                .hold_o     (hold[g])
            );
        end
    endgenerate

    assign slot_free   = !out_valid_q || out_ready_i;
    assign any_pending = |pending;
    assign grant_en    = slot_free && any_pending && !rst_i;
    assign start_idx   = (last_grant_q == LAST_CH) ? '0 : last_grant_q + 1'b1;

    // Lowest pending index overall covers the wrap; lowest at or above start overrides it.
    always_comb begin
        grant_idx = '0;
        grant_val = '0;
        for (int i = NB_CAPTURES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_idx = CH_BITWIDTH'(i);
                grant_val = hold[i];
            end
        end
        for (int i = NB_CAPTURES - 1; i >= 0; i--) begin
            if (pending[i] && (CH_BITWIDTH'(i) >= start_idx)) begin
                grant_idx = CH_BITWIDTH'(i);
                grant_val = hold[i];
            end
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_channel_d = out_channel_q;
        out_value_d   = out_value_q;
        last_grant_d  = last_grant_q;
        if (rst_i) begin
            out_valid_d   = 1'b0;
            out_channel_d = '0;
            out_value_d   = '0;
            last_grant_d  = LAST_CH;
        end else if (slot_free) begin
            out_valid_d = any_pending;
            if (any_pending) begin
                out_channel_d = grant_idx;
                out_value_d   = grant_val;
                last_grant_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_value_q   <= '0;
            last_grant_q  <= LAST_CH;
        end else begin
            out_valid_q   <= out_valid_d;
            out_channel_q <= out_channel_d;
            out_value_q   <= out_value_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_channel_o = out_channel_q;
    assign out_value_o   = out_value_q;
    assign pending_o     = pending;
    assign overflow_o    = overflow;
endmodule
